// File: rtl/divider_clk_gen.sv
// Integer clock divider: clk_5m = clk / DIV_N, driven only from flops.
// Define DIVIDER_DUTY50_EN to get an exact 50 % duty for odd DIV_N via a negedge flop.
`timescale 1ns/1ps
module divider_clk_gen #(
  parameter int DIV_N = 20,
  parameter int CNT_W = $clog2(DIV_N)
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_5m
);

  localparam bit ODD     = (DIV_N % 2) != 0;
  localparam int RISE_AT = ODD ? (DIV_N - 1) / 2 : DIV_N / 2 - 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_N - 1);
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(RISE_AT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (DIV_N < 2) begin : g_bad_div
    $error("divider_clk_gen: DIV_N must be >= 2");
  end

  if (CNT_W < $clog2(DIV_N)) begin : g_bad_cnt_w
    $error("divider_clk_gen: CNT_W too small for DIV_N");
  end

  logic [CNT_W-1:0] cnt;
  logic             q_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Set/clear form; for even DIV_N this is the same as toggling at both decode points.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p <= 1'b0;
    end else if (cnt == CNT_RISE) begin
      q_p <= 1'b1;
    end else if (cnt == CNT_LAST) begin
      q_p <= 1'b0;
    end
  end

`ifdef DIVIDER_DUTY50_EN
  if (ODD) begin : g_duty50
    logic q_n;

    // q_n stretches each high phase by half an input period; OR of two flops cannot glitch
    // because q_n only rises while q_p is already high.
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_n <= 1'b0;
      end else begin
        q_n <= q_p;
      end
    end

    assign clk_5m = q_p | q_n;
  end else begin : g_plain
    assign clk_5m = q_p;
  end
`else
  assign clk_5m = q_p;
`endif

endmodule

// File: tb/tb_divider_clk_gen.sv
// Directed bench for divider_clk_gen: DIV_N = 20, 4 and 5 instances sharing clk/rst_n.
`timescale 1ns/1ps
module tb_divider_clk_gen;

  logic clk;
  logic rst_n;
  logic o20, o4, o5;

  int n_vec = 0;
  int n_err = 0;

  divider_clk_gen #(.DIV_N(20)) u20 (.clk(clk), .rst_n(rst_n), .clk_5m(o20));
  divider_clk_gen #(.DIV_N(4))  u4  (.clk(clk), .rst_n(rst_n), .clk_5m(o4));
  divider_clk_gen #(.DIV_N(5))  u5  (.clk(clk), .rst_n(rst_n), .clk_5m(o5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   k;
    logic e20;
    logic e4;
    logic e5;
    logic e5d;
  } vec_t;

  vec_t tbl[16];

`ifdef DIVIDER_DUTY50_EN
  localparam int HI5 = 25;
`else
  localparam int HI5 = 20;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sel(input int idx);
    case (idx)
      0:       return o20;
      1:       return o4;
      default: return o5;
    endcase
  endfunction

  task automatic wait_edge(input int idx, input logic val, output realtime t, output bit ok);
    logic prev;
    ok = 1'b0;
    t  = 0;
    for (int n = 0; n < 1000; n++) begin
      prev = sel(idx);
      #1;
      if (prev !== val && sel(idx) === val) begin
        t  = $realtime;
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Samples at half-ns offsets so detected transitions never race the clock edges.
  task automatic measure(input int idx, output int per, output int hi);
    realtime tr, tf, tr2;
    bit ok1, ok2, ok3;
    per = -1;
    hi  = -1;
    @(posedge clk);
    #0.5;
    wait_edge(idx, 1'b1, tr, ok1);
    wait_edge(idx, 1'b0, tf, ok2);
    wait_edge(idx, 1'b1, tr2, ok3);
    if (ok1 && ok2 && ok3) begin
      per = int'(tr2 - tr);
      hi  = int'(tf - tr);
    end
  endtask

  task automatic run_table(input string tag);
    int cur = 0;
    for (int i = 0; i < 16; i++) begin
      repeat (tbl[i].k - cur) @(posedge clk);
      cur = tbl[i].k;
      #1;
      check($sformatf("%s_div20_k%0d", tag, tbl[i].k), o20, tbl[i].e20);
      check($sformatf("%s_div4_k%0d", tag, tbl[i].k), o4, tbl[i].e4);
`ifdef DIVIDER_DUTY50_EN
      check($sformatf("%s_div5_k%0d", tag, tbl[i].k), o5, tbl[i].e5d);
`else
      check($sformatf("%s_div5_k%0d", tag, tbl[i].k), o5, tbl[i].e5);
`endif
    end
  endtask

  initial begin
    int per, hi, bad;
    bit seen;

    //             k   e20   e4    e5    e5d   (sampled 1 ns after the k-th rising edge after release)
    tbl[0]  = '{ 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{ 2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{ 3, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{ 4, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{ 5, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{ 6, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{ 8, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{ 9, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{10, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{11, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{12, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{19, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{20, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{21, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{30, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{40, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset hold for 100 ns with clk running.
    rst_n = 1'b0;
    #7;
    for (int i = 0; i < 10; i++) begin
      check("rst_hold_div20", o20, 0);
      check("rst_hold_div4", o4, 0);
      check("rst_hold_div5", o5, 0);
      check("rst_hold_cnt20", int'(u20.cnt), 0);
      if (i < 9) #10;
    end
    #3;
    rst_n = 1'b1;

    run_table("post_rst");

    // 50 output periods of the default divider.
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      measure(0, per, hi);
      if (per != 200 || hi != 100) bad++;
    end
    check("div20_period_hi_bad_count", bad, 0);
    measure(0, per, hi);
    check("div20_period_ns", per, 200);
    check("div20_high_ns", hi, 100);

    measure(1, per, hi);
    check("div4_period_ns", per, 40);
    check("div4_high_ns", hi, 20);

    bad = 0;
    for (int i = 0; i < 10; i++) begin
      measure(2, per, hi);
      if (per != 50 || hi != HI5) bad++;
    end
    check("div5_period_hi_bad_count", bad, 0);
    measure(2, per, hi);
    check("div5_period_ns", per, 50);
    check("div5_high_ns", hi, HI5);

    // Asynchronous reset while the divided clock is high.
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (o20 === 1'b1) seen = 1'b1;
    end
    check("mid_rst_found_high", int'(seen), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_div20_async", o20, 0);
    check("mid_rst_div4_async", o4, 0);
    check("mid_rst_div5_async", o5, 0);
    check("mid_rst_cnt20", int'(u20.cnt), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_div20_held", o20, 0);
    rst_n = 1'b1;

    run_table("mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/divider_clk_gen.md
Name: divider_clk_gen

Overview:
- Integer clock divider. Generates a lower-frequency clock output from the system clock.
- Default configuration: 100 MHz clk (10 ns period) in, 5 MHz clk_5m (200 ns period, 50 % duty) out.
- Sits at the top of the clocking path. Its output clocks slow peripheral logic.

Parameters:
- DIV_N, 20, division ratio (integer >= 2). Output period = DIV_N input periods.
- CNT_W, $clog2(DIV_N), width of the internal cycle counter. Derived; must not be overridden smaller.

Ports:
- clk  input  1  system clock, rising-edge active (100 MHz nominal)
- rst_n  input  1  asynchronous active-low reset
- clk_5m  output  1  divided clock, registered (glitch-free), frequency = f(clk)/DIV_N

Behaviour:
- Clocking and reset:
  - One clock domain: clk.
  - Reset is asynchronous and active-low (rst_n).
  - Assertion immediately forces counter = 0 and clk_5m = 0, independent of clk.
  - Deassertion takes effect at the next clk rising edge.
- Counter:
  - cnt counts 0..DIV_N-1 on each clk rising edge, then wraps to 0.
  - No other states; free-running whenever rst_n = 1.
- Even DIV_N:
  - clk_5m toggles on the rising edge where cnt == DIV_N/2-1, and on the rising edge where cnt == DIV_N-1.
  - Result: clk_5m is low for DIV_N/2 input cycles, then high for DIV_N/2 input cycles.
  - Default DIV_N = 20, first edge after reset release: clk_5m rises at the 10th clk rising edge and falls at the 20th. Period is 200 ns, high time 100 ns.
- Odd DIV_N, base behaviour:
  - A posedge register q_p is low for (DIV_N+1)/2 cycles and high for (DIV_N-1)/2 cycles.
  - q_p rises on the edge where cnt == (DIV_N-1)/2 and falls on the edge where cnt == DIV_N-1.
- Output registration: clk_5m is always driven from flops or an OR of flops. There is no combinational decode of cnt to the output.
- Reset mid-operation: output drops to 0 at once. The sequence restarts from cnt = 0, with the same first-edge timing as after power-up reset.
- Elaboration check: DIV_N < 2 is illegal and shall trigger an elaboration-time $error.
- Latency: the output is phase-locked to clk rising edges, with at most one register stage from the count decode.

Optional Feature:
- Macro: DIVIDER_DUTY50_EN
- Defined:
  - For odd DIV_N, add a negedge flop q_n that samples q_p on the clk falling edge.
  - clk_5m = q_p | q_n, giving an exact 50 % duty: high for DIV_N/2 input periods (e.g. 2.5 periods for DIV_N = 5).
  - q_n also resets asynchronously to 0.
- Not defined: for odd DIV_N, clk_5m = q_p, i.e. high (DIV_N-1)/2 and low (DIV_N+1)/2 input periods.
- Even DIV_N: behaviour is identical with or without the macro; the negedge flop is not used.

Test Plan:
- Reset hold, default DIV_N = 20: rst_n = 0 for 100 ns with clk running -> clk_5m = 0 throughout and cnt = 0.
- Release at 100 ns, DIV_N = 20 -> clk_5m rises at the 10th clk rising edge after release, falls at the 20th; measured period 200 ns, high 100 ns, low 100 ns, stable over at least 50 output periods.
- Mid-operation reset: assert rst_n = 0 while clk_5m = 1 (asynchronous, between clk edges) -> clk_5m goes 0 without waiting for a clk edge. After release, the first rise again occurs at the 10th clk edge.
- DIV_N = 4 -> output period 40 ns, 20 ns high / 20 ns low, first rise at the 2nd edge after release.
- DIV_N = 5 without DIVIDER_DUTY50_EN -> period 50 ns, high 20 ns, low 30 ns.
- DIV_N = 5 with DIVIDER_DUTY50_EN -> period 50 ns, high 25 ns, low 25 ns; no glitches at the q_p/q_n overlap.
